// File: rtl/fetch_pkg.sv
// fetch_pkg: shared FSM states, opcode constants and default vectors for instruction fetch
package fetch_pkg;
  typedef enum logic [1:0] {BOOT, FETCH, ISSUE} state_t;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J = 6'b000010;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR = 32'h8000_0180;
endpackage

// File: rtl/inst_fetch_unit_if.sv
// inst_fetch_unit_if: instruction memory req/ready bus between fetch unit and memory
interface inst_fetch_unit_if;
  logic imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic imem_ready;
  modport master(output imem_req, imem_addr, input imem_rdata, imem_ready);
  modport slave(input imem_req, imem_addr, output imem_rdata, imem_ready);
endinterface

// File: rtl/next_pc_calc.sv
// next_pc_calc: priority next-PC selection (exception > jump > taken branch > pc+4)
module next_pc_calc
  import fetch_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
  input  logic [31:0] pc,
  input  logic [31:0] inst,
  input  logic        Jump,
  input  logic        Branch,
  input  logic        alu_zero,
  input  logic        Exception,
  output logic [31:0] next_pc,
  output logic        take_exc
);
  logic [31:0] w_pc4, w_jmp, w_br;
  logic w_unused;
  assign w_unused = &{1'b0, inst[31:26]};
  assign w_pc4 = pc + 32'd4;
  assign w_jmp = {w_pc4[31:28], inst[25:0], 2'b00};
  assign w_br = w_pc4 + {{14{inst[15]}}, inst[15:0], 2'b00};
  assign take_exc = Exception;
  assign next_pc = Exception ? EXC_VECTOR : Jump ? w_jmp : (Branch && alu_zero) ? w_br : w_pc4;
endmodule

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: BOOT/FETCH/ISSUE sequencer fetching instructions and computing the next PC
module inst_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR,
  parameter int IMEM_TIMEOUT = 15
) (
  input  logic                      clk,
  input  logic                      rst_n,
  inst_fetch_unit_if.master         imem,
  output logic [31:0]               inst,
  output logic [5:0]                Inst_A,
  output logic                      inst_valid,
  input  logic                      Jump,
  input  logic                      Branch,
  input  logic                      Exception,
  input  logic                      alu_zero,
  input  logic                      stall,
  output logic [31:0]               pc,
  output logic [31:0]               epc,
  output logic                      fetch_err
);
  state_t r_state, w_next;
  logic [31:0] r_pc, r_inst, r_epc, w_next_pc;
  logic [3:0] r_cnt;
  logic r_err, w_timeout, w_fire, w_take_exc;
  assign w_timeout = r_state == FETCH && !imem.imem_ready && r_cnt == 4'(IMEM_TIMEOUT - 1);
  assign w_fire = r_state == ISSUE && !stall;
  next_pc_calc #(.EXC_VECTOR(EXC_VECTOR)) u_npc (
    .pc(r_pc), .inst(r_inst), .Jump(Jump), .Branch(Branch), .alu_zero(alu_zero),
    .Exception(Exception), .next_pc(w_next_pc), .take_exc(w_take_exc)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= BOOT;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    imem.imem_req = 1'b0;
    inst_valid = 1'b0;
    w_next = r_state == BOOT ? FETCH : r_state == FETCH ? (imem.imem_ready ? ISSUE : FETCH) : (stall ? ISSUE : FETCH);
    imem.imem_req = r_state == FETCH;
    inst_valid = r_state == ISSUE;
  end
  // ready beats a coincident timeout, so the error path is only taken with ready low
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_pc <= RESET_PC;
      r_inst <= '0;
      r_epc <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_err <= w_timeout;
      if (r_state == FETCH) begin
        if (imem.imem_ready) begin
          r_inst <= imem.imem_rdata;
          r_cnt <= '0;
        end else if (w_timeout) begin
          r_epc <= r_pc;
          r_pc <= EXC_VECTOR;
          r_cnt <= '0;
        end else r_cnt <= r_cnt + 4'd1;
      end
      if (w_fire) begin
        r_pc <= w_next_pc;
        if (w_take_exc) r_epc <= r_pc;
      end
    end
  assign imem.imem_addr = r_pc;
  assign inst = r_inst;
  assign Inst_A = r_inst[31:26];
  assign pc = r_pc;
  assign epc = r_epc;
  assign fetch_err = r_err;
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: directed plus randomized checks against a transaction-level fetch model
module tb_inst_fetch_unit;
  import fetch_pkg::*;
  localparam logic [31:0] EXC = 32'h8000_0180;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [31:0] inst, pc, epc;
  logic [5:0] Inst_A;
  logic inst_valid, fetch_err;
  logic Jump = 1'b0, Branch = 1'b0, Exception = 1'b0, alu_zero = 1'b0, stall = 1'b0;
  inst_fetch_unit_if bus();
  inst_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .imem(bus), .inst(inst), .Inst_A(Inst_A), .inst_valid(inst_valid),
    .Jump(Jump), .Branch(Branch), .Exception(Exception), .alu_zero(alu_zero), .stall(stall),
    .pc(pc), .epc(epc), .fetch_err(fetch_err)
  );
  always #5 clk = ~clk;
  logic [31:0] m_pc = 32'h0, m_epc = 32'h0, m_inst = 32'h0;
  bit e_req = 1'b0, e_valid = 1'b0, e_err = 1'b0, pend = 1'b0, chk_en = 1'b0;
  int n_chk = 0, n_pass = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
  endtask
  always @(negedge clk)
    if (chk_en) begin
      chk("req", 32'(bus.imem_req), 32'(e_req));
      chk("inst_valid", 32'(inst_valid), 32'(e_valid));
      chk("pc", pc, m_pc);
      chk("imem_addr", bus.imem_addr, m_pc);
      chk("epc", epc, m_epc);
      chk("fetch_err", 32'(fetch_err), 32'(e_err));
      if (e_valid) begin
        chk("inst", inst, m_inst);
        chk("Inst_A", 32'(Inst_A), 32'(m_inst[31:26]));
      end
    end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic boot();
    {Jump, Branch, Exception, alu_zero, stall} = '0;
    bus.imem_ready = 1'b0;
    bus.imem_rdata = '0;
    m_pc = 32'h0;
    m_epc = 32'h0;
    m_inst = 32'h0;
    e_req = 0; e_valid = 0; e_err = 0; pend = 0;
    rst_n = 1'b1;
    chk_en = 1'b1;
    chk("boot_req", 32'(bus.imem_req), 32'h0);
    tick();
  endtask
  task automatic fetch(input int w, input logic [31:0] word);
    int c = 0, k = 0;
    bit to;
    forever begin
      e_req = 1; e_valid = 0; e_err = pend; pend = 0;
      bus.imem_ready = (c == w);
      bus.imem_rdata = (c == w) ? word : $urandom;
      if (c == w) begin
        tick();
        break;
      end
      to = (k == 14);
      c++;
      tick();
      if (to) begin
        pend = 1; m_epc = m_pc; m_pc = EXC; k = 0;
      end else k++;
    end
    m_inst = word;
    bus.imem_ready = 1'b0;
  endtask
  task automatic issue(input int s, input bit j, input bit br, input bit z, input bit ex);
    logic [31:0] pc4, nxt, old;
    logic signed [31:0] off;
    e_req = 0; e_valid = 1; e_err = pend; pend = 0;
    repeat (s) begin
      stall = 1;
      {Jump, Branch, alu_zero, Exception} = 4'($urandom);
      tick();
      e_err = 0;
    end
    stall = 0;
    Jump = j; Branch = br; alu_zero = z; Exception = ex;
    old = m_pc;
    pc4 = m_pc + 32'd4;
    off = $signed(m_inst[15:0]);
    if (ex) nxt = EXC;
    else if (j) nxt = (pc4 & 32'hF000_0000) | ({6'b0, m_inst[25:0]} * 4);
    else if (br && z) nxt = pc4 + off * 4;
    else nxt = pc4;
    tick();
    m_pc = nxt;
    if (ex) m_epc = old;
    {Jump, Branch, alu_zero, Exception} = '0;
  endtask
  task automatic test1();
    boot();
    chk("t1_req", 32'(bus.imem_req), 32'h1);
    chk("t1_addr", bus.imem_addr, 32'h0);
    fetch(0, 32'h0000_0020);
    chk("t1_valid", 32'(inst_valid), 32'h1);
    chk("t1_opcode", 32'(Inst_A), 32'h0);
    issue(0, 0, 0, 0, 0);
    chk("t1_addr2", bus.imem_addr, 32'h4);
  endtask
  task automatic async_rst(input string name);
    chk_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk({name, "_req"}, 32'(bus.imem_req), 32'h0);
    chk({name, "_valid"}, 32'(inst_valid), 32'h0);
    chk({name, "_pc"}, pc, 32'h0);
    stall = 1'b0;
    tick();
  endtask
  logic [5:0] ops [5];
  initial begin
    ops = '{OP_RTYPE, OP_J, OP_BEQ, OP_LW, OP_SW};
    bus.imem_ready = 1'b0;
    bus.imem_rdata = '0;
    repeat (2) tick();
    chk("rst_req", 32'(bus.imem_req), 32'h0);
    chk("rst_inst", inst, 32'h0);
    test1();
    fetch(0, 32'h0800_0010);
    issue(0, 1, 0, 0, 0);
    chk("t2_jump", bus.imem_addr, 32'h40);
    fetch(0, 32'h0800_0004);
    issue(0, 1, 1, 1, 0);
    chk("t3_at10", bus.imem_addr, 32'h10);
    fetch(3, 32'h1000_FFFF);
    chk("t3_valid_after4", 32'(inst_valid), 32'h1);
    issue(0, 0, 1, 1, 0);
    chk("t3_taken", bus.imem_addr, 32'h10);
    fetch(3, 32'h1000_FFFF);
    issue(0, 0, 1, 0, 0);
    chk("t3_not_taken", bus.imem_addr, 32'h14);
    fetch(0, 32'h0800_0002);
    issue(0, 1, 0, 0, 0);
    chk("t4_at8", bus.imem_addr, 32'h8);
    fetch(0, 32'h8C00_0000);
    issue(3, 1, 1, 1, 1);
    chk("t4_epc", epc, 32'h8);
    chk("t4_exc_addr", bus.imem_addr, EXC);
    fetch(0, 32'h0800_0040);
    issue(0, 1, 0, 0, 0);
    chk("t5_at100", bus.imem_addr, 32'h8000_0100);
    fetch(16, 32'h0000_0020);
    chk("t5_epc", epc, 32'h8000_0100);
    chk("t5_pc", pc, EXC);
    issue(0, 0, 0, 0, 0);
    async_rst("t6_fetch");
    test1();
    fetch(0, 32'h1000_FFFD);
    issue(0, 0, 1, 1, 0);
    chk("t5_wrap_pc", bus.imem_addr, 32'hFFFF_FFFC);
    fetch(1, 32'hAC00_0000);
    issue(0, 0, 0, 0, 0);
    chk("t5_wrap_zero", bus.imem_addr, 32'h0);
    fetch(0, 32'h8C00_0000);
    stall = 1'b1;
    e_req = 0; e_valid = 1; e_err = 0;
    tick();
    async_rst("t6_stall");
    test1();
    for (int n = 0; n < 300; n++) begin
      int w;
      logic [31:0] word;
      w = ($urandom_range(0, 19) == 0) ? int'($urandom_range(14, 17)) : int'($urandom_range(0, 3));
      word = {ops[$urandom_range(0, 4)], 26'($urandom)};
      fetch(w, word);
      issue($urandom_range(0, 2), 1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 9) == 0);
    end
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
